seq_shift_add_mult: RTL
=======================

// Module: seq_shift_add_mult
// PURPOSE
//   Parametrised iterative shift-add multiplier; successor to the fixed-flow multiplier.
//   Adds a start/busy/done handshake, per-operation signed/unsigned mode and independent
//   operand widths. Processes one multiplier bit per cycle, so it costs one adder.
//   Used by datapath controllers that tolerate N-cycle latency in exchange for area.
// PARAMETERS
//   M  4  multiplicand (a) width, M >= 2
//   N  4  multiplier (b) width, N >= 2; also the iteration count
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   rst        in   1    synchronous, active-low reset (sampled on clk rising edge)
//   start      in   1    request; accepted only in IDLE or DONE
//   is_signed  in   1    1: a, b are two's complement; 0: unsigned; latched with start
//   a          in   M    multiplicand; latched on accepting edge
//   b          in   N    multiplier; latched on accepting edge
//   busy       out  1    high while iterating
//   done       out  1    one-cycle pulse; product valid
//   product    out  M+N  result; held stable until next accepted start
// BEHAVIOUR
//   Reset (rst==0 at edge): state=IDLE, busy=0, done=0, product=0, counters/regs cleared.
//     Reset overrides start and wins mid-operation; the partial result is discarded.
//   FSM: IDLE -start-> BUSY. BUSY -(iteration N-1 complete)-> DONE.
//        DONE -start-> BUSY, else -> IDLE.
//   Accept: edge k with state IDLE/DONE and start=1; latch a, b and is_signed; clear acc;
//     set busy. From edge k+1, operand inputs are don't-care.
//   Iteration i (i=0..N-1), one per edge k+1..k+N:
//     if b_reg[i]: acc += (A_ext << i), A_ext = a_reg sign-extended (signed) or
//     zero-extended (unsigned) to M+N bits.
//     Signed mode and i==N-1: subtract instead of add (two's-complement MSB weight).
//     All arithmetic modulo 2^(M+N); the exact product always fits.
//   Edge k+N: product <= final acc; busy=0; done=1 for exactly one cycle.
//     Latency: N edges from accept to done.
//   start while busy=1: ignored; no effect on operands, mode or timing.
//   start while done=1: accepted (back-to-back). busy=1 next cycle; done drops.
//     product holds the old value until the new done.
//   product changes only at the completing edge or at reset; it never shows partial sums.
//   busy and done are never high together.
//   Corner operands: a=0 or b=0 still take N cycles.
//     Signed most-negative x most-negative is exact,
//     e.g. M=N=4: -8*-8 = +64 = 8'h40.
// TESTING (M=N=4 unless stated; check busy/done timing on every case)
//   1. unsigned a=4'hF, b=4'hF -> done at accept+4, product=8'hE1 (225), busy high 4 cycles
//   2. signed a=4'hF (-1), b=4'hF (-1) -> product=8'h01; signed a=4'h8 (-8), b=4'h7
//      -> 8'hC8 (-56); signed a=4'h8, b=4'h8 -> 8'h40
//   3. unsigned a=4'hC, b=4'h2 -> 8'h18; a=0, b=4'hF -> 8'h00 with full 4-cycle latency
//   4. start pulsed again mid-op with a=4'h3, b=4'h3 -> ignored; first result is unchanged.
//      Then start in the done cycle with 3*3 -> next done 4 edges later, product=8'h09
//   5. rst=0 on 2nd busy cycle -> next cycle busy=0, done=0, product=0, state IDLE.
//      A fresh start then completes normally
//   6. M=8, N=4: unsigned 8'hFF*4'hF -> 12'hEF1; signed 8'h80*4'h7 -> 12'hC80 (-896)

Source files
------------

// File: rtl/seq_shift_add_mult_if.sv
// Request/response bundle for the iterative shift-add multiplier.
// The master drives the operands and start; the slave returns busy/done/product.
interface seq_shift_add_mult_if #(
    parameter int M = 4,
    parameter int N = 4
);
    logic             start;
    logic             is_signed;
    logic [M-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [M+N-1:0]   product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle through a single
// add/subtract unit. Operands and signed/unsigned mode are latched on the
// accepting edge; the product appears N edges later with a one-cycle done pulse.
module seq_shift_add_mult #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_shift_add_mult_if.slave   bus
);
    localparam int W  = M + N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           sgn_q, sgn_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   prod_q, prod_d;

    logic [W-1:0]   a_ext;
    logic [W-1:0]   term;
    logic           sub;
    logic [W-1:0]   acc_nx;

    // Datapath for the current iteration: the partial product for bit cnt_q,
    // subtracted at the MSB in signed mode to give it negative weight.
    always_comb begin
        a_ext  = {{N{a_q[M-1] & sgn_q}}, a_q};
        term   = a_ext << cnt_q;
        sub    = sgn_q && (cnt_q == LAST);
        acc_nx = acc_q;
        if (b_q[cnt_q])
            acc_nx = acc_q + (sub ? ~term : term) + W'(sub);
    end

    // Next-state and register-update logic; product is only ever loaded with a
    // finished accumulation so partial sums never reach the output.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_BUSY: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    prod_d  = acc_nx;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request (DONE gives back-to-back).
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sgn_d   = bus.is_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = (state_q == S_BUSY);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = prod_q;
endmodule
